pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the fetch stage: holds the current PC,
//  advances by INSTR_BYTES, honours stall, branch/jump redirect and trap, and keeps a
//  small return-address stack (RAS) for predicted returns. It drives the instruction
//  memory address, and execute/control logic drives its redirect and RAS inputs.
// PARAMETERS
//  XLEN          32            PC / address width in bits
//  INSTR_BYTES   4             PC increment; power of two; also the alignment requirement
//  RESET_VECTOR  32'h0000_0000 PC value loaded by reset
//  TRAP_VECTOR   32'h0000_0100 PC value loaded on a trap or a misaligned redirect
//  RAS_DEPTH     4             RAS entries; power of two, >= 2
// PORTS
//  clk               in   1     clock, rising edge
//  reset             in   1     asynchronous, active-high reset
//  stall_i           in   1     hold the PC; RAS push/pop are ignored
//  trap_i            in   1     next PC = TRAP_VECTOR; the RAS is flushed
//  redirect_valid_i  in   1     branch/jump taken
//  redirect_target_i in   XLEN  redirect destination
//  ras_push_i        in   1     push ras_push_addr_i (call)
//  ras_push_addr_i   in   XLEN  return address to push
//  ras_pop_i         in   1     return: next PC = RAS top
//  pc_o              out  XLEN  current PC (registered)
//  pc_valid_o        out  1     pc_o is a valid fetch address
//  misaligned_o      out  1     one-cycle pulse: the last redirect target was misaligned
//  ras_empty_o       out  1     RAS holds 0 entries
//  ras_full_o        out  1     RAS holds RAS_DEPTH entries
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): pc_o=RESET_VECTOR, pc_valid_o=0,
//    misaligned_o=0, RAS count=0 (ras_empty_o=1, ras_full_o=0).
//  - pc_valid_o goes to 1 on the first rising edge after reset deasserts and stays 1.
//  - All updates are registered: the selected next PC appears on pc_o one cycle after
//    the inputs are sampled.
//  - Next-PC priority, highest first:
//    1. trap_i: TRAP_VECTOR; RAS flushed; push/pop ignored.
//    2. redirect_valid_i with target[log2(INSTR_BYTES)-1:0]==0: redirect_target_i.
//    3. redirect_valid_i with a misaligned target: TRAP_VECTOR, misaligned_o=1 next cycle,
//       RAS flushed.
//    4. stall_i: hold pc_o; RAS unchanged.
//    5. ras_pop_i with RAS not empty: RAS top; count decrements.
//    6. Otherwise: pc_o + INSTR_BYTES, modulo 2^XLEN (wraps silently at the top).
//  - ras_pop_i with the RAS empty: treated as case 6; count stays 0.
//  - ras_push_i (when not stalled/trapped/misaligned): entry written at top+1.
//    If the RAS is full, the oldest entry is overwritten (circular); count stays RAS_DEPTH.
//  - Push and pop in the same cycle: the next PC is the old top; the top entry is
//    replaced by ras_push_addr_i; count is unchanged. If the RAS is empty, this is a
//    plain push.
//  - A redirect (aligned) leaves the RAS intact and still accepts push/pop in that
//    cycle, but the pop does not affect the next PC.
//  - misaligned_o is high for exactly one cycle per misaligned redirect. It is 0 otherwise.
// STRUCTURE
//  - Shared package pc_pkg: XLEN default, RESET_VECTOR/TRAP_VECTOR defaults, and the
//    next-PC select enum {SEL_TRAP, SEL_REDIR, SEL_MISAL, SEL_HOLD, SEL_RAS, SEL_INC}.
//  - Sub-module pc_ras:
//    - circular stack with a top pointer and a saturating count;
//    - ports push/pop/flush/push_addr/top/empty/full;
//    - async reset.
//  - Top level: priority select, PC register, valid/misaligned flops.
// TESTING
//  1. Reset release with defaults, 4 free-running clocks -> pc_o 0x0,0x4,0x8,0xC;
//     pc_valid_o 0 then 1.
//  2. stall_i=1 for 3 cycles at pc=0x8 -> pc_o holds 0x8; with a simultaneous
//     redirect to 0x40 -> pc_o=0x40 next cycle.
//  3. Redirect target 0x42 -> pc_o=0x100, misaligned_o=1 for one cycle, RAS empty.
//  4. Push 0x10,0x20,0x30,0x40,0x50 (depth 4) -> ras_full_o=1; four pops yield
//     pc 0x50,0x40,0x30,0x20; a fifth pop increments (0x24).
//  5. Push 0xA0 and pop in the same cycle with top=0x20 -> next pc=0x20;
//     top becomes 0xA0; count unchanged.
//  6. Assert reset asynchronously mid-stall at pc=0x1C -> pc_o=0x0 immediately;
//     pc_valid_o=0, ras_empty_o=1; pc_o=0xFFFF_FFFC then 0x0 on increment wrap.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer.
package pc_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    // Next-PC source, listed in priority order (highest first).
    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_REDIR,
        SEL_MISAL,
        SEL_HOLD,
        SEL_RAS,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/redirect/RAS bundle between execute logic (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            trap_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_target_i;
    logic            ras_push_i;
    logic [XLEN-1:0] ras_push_addr_i;
    logic            ras_pop_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            misaligned_o;
    logic            ras_empty_o;
    logic            ras_full_o;

    modport master (
        output stall_i, trap_i, redirect_valid_i, redirect_target_i,
               ras_push_i, ras_push_addr_i, ras_pop_i,
        input  pc_o, pc_valid_o, misaligned_o, ras_empty_o, ras_full_o
    );

    modport slave (
        input  stall_i, trap_i, redirect_valid_i, redirect_target_i,
               ras_push_i, ras_push_addr_i, ras_pop_i,
        output pc_o, pc_valid_o, misaligned_o, ras_empty_o, ras_full_o
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: top pointer plus saturating count.
// When full, a push overwrites the oldest entry by wrapping the pointer.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] push_addr_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_replace;
    logic             w_push_only;
    logic             w_pop_only;
    logic [PTR_W-1:0] w_wr_idx;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    // A pop on an empty stack is dropped, so push+pop there degrades to a plain push.
    assign w_pop_ok    = pop_i & ~w_empty & ~flush_i;
    assign w_replace   = push_i & w_pop_ok & ~flush_i;
    assign w_push_only = push_i & ~w_pop_ok & ~flush_i;
    assign w_pop_only  = w_pop_ok & ~push_i;
    assign w_wr_idx    = w_replace ? r_top : r_top + PTR_W'(1);

    assign top_o   = r_mem[r_top];
    assign empty_o = w_empty;
    assign full_o  = w_full;

    // Entry storage: replace the top on push+pop, otherwise write above the top.
    always_ff @(posedge clk) begin
        if (w_replace || w_push_only) begin
            r_mem[w_wr_idx] <= push_addr_i;
        end
    end

    // Pointer and occupancy; flush only clears the count, stale entries are unreachable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_push_only) begin
            r_top <= r_top + PTR_W'(1);
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop_only) begin
            r_top   <= r_top - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: priority next-PC select, PC register, valid and
// misaligned-redirect flops, with a return-address stack for predicted returns.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic            r_misal;

    pc_sel_e         w_sel;
    logic [XLEN-1:0] w_pc_next;
    logic            w_aligned;
    logic            w_ras_flush;
    logic            w_ras_push;
    logic            w_ras_pop;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    assign w_aligned = ((bus.redirect_target_i & ALIGN_MASK) == '0);

    // Next-PC source selection in strict priority order.
    always_comb begin
        w_sel = SEL_INC;
        if (bus.trap_i) begin
            w_sel = SEL_TRAP;
        end else if (bus.redirect_valid_i && w_aligned) begin
            w_sel = SEL_REDIR;
        end else if (bus.redirect_valid_i) begin
            w_sel = SEL_MISAL;
        end else if (bus.stall_i) begin
            w_sel = SEL_HOLD;
        end else if (bus.ras_pop_i && !w_ras_empty) begin
            w_sel = SEL_RAS;
        end
    end

    // Next-PC value for the chosen source; increment wraps modulo 2^XLEN.
    always_comb begin
        w_pc_next = r_pc + PC_STEP;
        case (w_sel)
            SEL_TRAP:  w_pc_next = TRAP_VECTOR;
            SEL_REDIR: w_pc_next = bus.redirect_target_i;
            SEL_MISAL: w_pc_next = TRAP_VECTOR;
            SEL_HOLD:  w_pc_next = r_pc;
            SEL_RAS:   w_pc_next = w_ras_top;
            default:   w_pc_next = r_pc + PC_STEP;
        endcase
    end

    // Traps and misaligned redirects discard predictions; stall freezes the stack,
    // even when an aligned redirect overrides the stall for the PC itself.
    assign w_ras_flush = (w_sel == SEL_TRAP) || (w_sel == SEL_MISAL);
    assign w_ras_push  = bus.ras_push_i & ~bus.stall_i & ~w_ras_flush;
    assign w_ras_pop   = bus.ras_pop_i & ~bus.stall_i & ~w_ras_flush;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_ras_push),
        .pop_i       (w_ras_pop),
        .flush_i     (w_ras_flush),
        .push_addr_i (bus.ras_push_addr_i),
        .top_o       (w_ras_top),
        .empty_o     (w_ras_empty),
        .full_o      (w_ras_full)
    );

    // PC register, fetch-valid flag and one-cycle misaligned-redirect pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_VECTOR;
            r_valid <= 1'b0;
            r_misal <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_valid <= 1'b1;
            r_misal <= (w_sel == SEL_MISAL);
        end
    end

    assign bus.pc_o         = r_pc;
    assign bus.pc_valid_o   = r_valid;
    assign bus.misaligned_o = r_misal;
    assign bus.ras_empty_o  = w_ras_empty;
    assign bus.ras_full_o   = w_ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PCs and flags.
module tb_pc_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic drive(input logic stall, input logic trap, input logic rv,
                         input logic [31:0] rt, input logic push,
                         input logic [31:0] pa, input logic pop);
        bus.stall_i           = stall;
        bus.trap_i            = trap;
        bus.redirect_valid_i  = rv;
        bus.redirect_target_i = rt;
        bus.ras_push_i        = push;
        bus.ras_push_addr_i   = pa;
        bus.ras_pop_i         = pop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle();
        repeat (3) tick();
        check_eq("rst_pc", bus.pc_o, 32'h0);
        check_eq("rst_valid", {31'b0, bus.pc_valid_o}, 32'h0);
        reset = 1'b0;
        #1;
        check_eq("rel_pc", bus.pc_o, 32'h0);
        check_eq("rel_valid", {31'b0, bus.pc_valid_o}, 32'h0);
        check_eq("rel_empty", {31'b0, bus.ras_empty_o}, 32'h1);
        check_eq("rel_full", {31'b0, bus.ras_full_o}, 32'h0);
        check_eq("rel_misal", {31'b0, bus.misaligned_o}, 32'h0);

        // Free-running increment
        tick(); check_eq("inc1", bus.pc_o, 32'h4);
        check_eq("valid1", {31'b0, bus.pc_valid_o}, 32'h1);
        tick(); check_eq("inc2", bus.pc_o, 32'h8);
        tick(); check_eq("inc3", bus.pc_o, 32'hC);

        // Back to 0x8, then stall three cycles (push during stall is ignored)
        drive(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        tick(); check_eq("redir8", bus.pc_o, 32'h8);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h66, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); check_eq($sformatf("stall%0d", i), bus.pc_o, 32'h8);
        end
        check_eq("stall_nopush", {31'b0, bus.ras_empty_o}, 32'h1);
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        tick(); check_eq("stall_redir", bus.pc_o, 32'h40);

        // Misaligned redirect with a push that must be ignored
        drive(1'b0, 1'b0, 1'b1, 32'h42, 1'b1, 32'h99, 1'b0);
        tick(); check_eq("misal_pc", bus.pc_o, 32'h100);
        check_eq("misal_pulse", {31'b0, bus.misaligned_o}, 32'h1);
        check_eq("misal_empty", {31'b0, bus.ras_empty_o}, 32'h1);
        idle();
        tick(); check_eq("misal_after", bus.pc_o, 32'h104);
        check_eq("misal_clear", {31'b0, bus.misaligned_o}, 32'h0);

        // Five pushes into a depth-4 stack: 0x10 is overwritten
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 16), 1'b0);
            tick(); check_eq($sformatf("push%0d_pc", i), bus.pc_o, 32'h104 + 32'(i * 4));
            check_eq($sformatf("push%0d_full", i), {31'b0, bus.ras_full_o}, (i >= 4) ? 32'h1 : 32'h0);
        end
        check_eq("push_empty", {31'b0, bus.ras_empty_o}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick(); check_eq("pop1", bus.pc_o, 32'h50);
        check_eq("pop1_full", {31'b0, bus.ras_full_o}, 32'h0);
        tick(); check_eq("pop2", bus.pc_o, 32'h40);
        tick(); check_eq("pop3", bus.pc_o, 32'h30);
        tick(); check_eq("pop4", bus.pc_o, 32'h20);
        check_eq("pop4_empty", {31'b0, bus.ras_empty_o}, 32'h1);
        tick(); check_eq("pop5_inc", bus.pc_o, 32'h24);
        check_eq("pop5_empty", {31'b0, bus.ras_empty_o}, 32'h1);

        // Push+pop replaces the top
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        tick(); check_eq("pp_a", bus.pc_o, 32'h28);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
        tick(); check_eq("pp_b", bus.pc_o, 32'h2C);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b1);
        tick(); check_eq("pp_pc", bus.pc_o, 32'h20);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick(); check_eq("pp_top", bus.pc_o, 32'hA0);
        tick(); check_eq("pp_next", bus.pc_o, 32'h10);
        check_eq("pp_empty", {31'b0, bus.ras_empty_o}, 32'h1);

        // Aligned redirect keeps the RAS live: push then pop, pop does not steer PC
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h33, 1'b0);
        tick(); check_eq("rd_push_pc", bus.pc_o, 32'h200);
        check_eq("rd_push_empty", {31'b0, bus.ras_empty_o}, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        tick(); check_eq("rd_pop_pc", bus.pc_o, 32'h300);
        check_eq("rd_pop_empty", {31'b0, bus.ras_empty_o}, 32'h1);

        // Trap flushes and ignores the concurrent push
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0);
        tick(); check_eq("tr_pre", bus.pc_o, 32'h304);
        drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h55, 1'b1);
        tick(); check_eq("trap_pc", bus.pc_o, 32'h100);
        check_eq("trap_empty", {31'b0, bus.ras_empty_o}, 32'h1);
        check_eq("trap_misal", {31'b0, bus.misaligned_o}, 32'h0);

        // Asynchronous reset in the middle of a stall
        drive(1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h77, 1'b0);
        tick(); check_eq("pre_rst_pc", bus.pc_o, 32'h1C);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(); check_eq("pre_rst_stall", bus.pc_o, 32'h1C);
        check_eq("pre_rst_empty", {31'b0, bus.ras_empty_o}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_pc", bus.pc_o, 32'h0);
        check_eq("arst_valid", {31'b0, bus.pc_valid_o}, 32'h0);
        check_eq("arst_empty", {31'b0, bus.ras_empty_o}, 32'h1);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        tick(); check_eq("wrap_top", bus.pc_o, 32'hFFFF_FFFC);
        check_eq("wrap_valid", {31'b0, bus.pc_valid_o}, 32'h1);
        idle();
        tick(); check_eq("wrap_zero", bus.pc_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
